fifo_wr_ctrl: RTL and testbench



---
 rtl/fifo_wr_ctrl.sv | 123 ++++++++++++
 tb/tb_fifo_wr_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller of an asynchronous FIFO.
// Accepts pushes in the wclk domain and drives the BRAM write port.
// It keeps binary and Gray write pointers and brings the read-domain Gray
// pointer into wclk through a two-flop synchronizer. From these it derives
// registered full, almost-full and writer-view occupancy.
// The optional overflow counter (ovf_cnt/ovf_clr) is enabled by defining
// FIFO_WR_OVF_CNT_EN.
//
// Handshake: a push is accepted on a wclk edge when push=1 and full=0. The
// word is written to the BRAM on that same edge. A push while full is dropped.
module fifo_wr_ctrl #(
    parameter int DEPTH    = 16,
    parameter int DWIDTH   = 32,
    parameter int AFULL_TH = 14,
    localparam int AWIDTH  = $clog2(DEPTH),
    localparam int PW      = AWIDTH + 1
) (
    input  logic              wclk,
    input  logic              arst,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    output logic              full,
    output logic              afull,
    output logic [PW-1:0]     wr_cnt,
    input  logic [PW-1:0]     rptr_gray,
    output logic [PW-1:0]     wptr_gray,
`ifdef FIFO_WR_OVF_CNT_EN
    input  logic              ovf_clr,
    output logic [7:0]        ovf_cnt,
`endif
    output logic              mem_wen,
    output logic [AWIDTH-1:0] mem_waddr,
    output logic [DWIDTH-1:0] mem_wdata
);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] rq1_q, rq2_q;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] cnt_d;
    logic [PW-1:0] wr_cnt_q;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          accept;

    // Reset also masks the BRAM write, so a push in flight during reset is dropped.
    assign accept = push & ~full_q & ~arst;

    // Next pointers, synchronized read pointer in binary, and the status terms.
    always_comb begin
        wbin_d  = wbin_q + {{(PW-1){1'b0}}, accept};
        wgray_d = wbin_d ^ (wbin_d >> 1);
        rbin_s  = '0;
        for (int i = 0; i < PW; i++) begin
            rbin_s[i] = ^(rq2_q >> i);
        end
        cnt_d   = wbin_d - rbin_s;
        // Full when the write pointer is exactly one lap (DEPTH) ahead of the read pointer.
        full_d  = (wgray_d == {~rq2_q[PW-1:PW-2], rq2_q[PW-3:0]});
        afull_d = (cnt_d >= PW'(AFULL_TH));
    end

    // Write pointer registers, binary for addressing and Gray for the read domain.
    always_ff @(posedge wclk or posedge arst) begin
        if (arst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
        end
    end

    // Two-flop synchronizer for the read-domain Gray pointer.
    always_ff @(posedge wclk or posedge arst) begin
        if (arst) begin
            rq1_q <= '0;
            rq2_q <= '0;
        end else begin
            rq1_q <= rptr_gray;
            rq2_q <= rq1_q;
        end
    end

    // Registered status. Read-side advances show up here only after the sync delay.
    always_ff @(posedge wclk or posedge arst) begin
        if (arst) begin
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            wr_cnt_q <= '0;
        end else begin
            full_q   <= full_d;
            afull_q  <= afull_d;
            wr_cnt_q <= cnt_d;
        end
    end

`ifdef FIFO_WR_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;

    // Count dropped pushes and saturate at 255. A clear takes priority over the increment.
    always_ff @(posedge wclk or posedge arst) begin
        if (arst) begin
            ovf_cnt_q <= '0;
        end else if (ovf_clr) begin
            ovf_cnt_q <= '0;
        end else if (push && full_q && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

    assign full      = full_q;
    assign afull     = afull_q;
    assign wr_cnt    = wr_cnt_q;
    assign wptr_gray = wgray_q;
    assign mem_wen   = accept;
    assign mem_waddr = wbin_q[AWIDTH-1:0];
    assign mem_wdata = push_data;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: randomized bench for fifo_wr_ctrl against a count-based model.
// The model tracks total writes and total reads as plain integers.
// Occupancy is total writes minus the read total the writer could see
// (reads lag by the synchronizer plus one register stage).
module tb_fifo_wr_ctrl;

    localparam int DEPTH    = 16;
    localparam int DWIDTH   = 32;
    localparam int AFULL_TH = 14;
    localparam int AW       = 4;
    localparam int PW       = 5;
    localparam int SW       = 2 * PW + 2;

    logic              wclk = 1'b0;
    logic              arst;
    logic              push;
    logic [DWIDTH-1:0] push_data;
    logic              full;
    logic              afull;
    logic [PW-1:0]     wr_cnt;
    logic [PW-1:0]     rptr_gray;
    logic [PW-1:0]     wptr_gray;
    logic              mem_wen;
    logic [AW-1:0]     mem_waddr;
    logic [DWIDTH-1:0] mem_wdata;
`ifdef FIFO_WR_OVF_CNT_EN
    logic              ovf_clr;
    logic [7:0]        ovf_cnt;
`endif

    fifo_wr_ctrl #(
        .DEPTH    (DEPTH),
        .DWIDTH   (DWIDTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .wclk      (wclk),
        .arst      (arst),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .afull     (afull),
        .wr_cnt    (wr_cnt),
        .rptr_gray (rptr_gray),
        .wptr_gray (wptr_gray),
`ifdef FIFO_WR_OVF_CNT_EN
        .ovf_clr   (ovf_clr),
        .ovf_cnt   (ovf_cnt),
`endif
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    // Clock.
    always #5 wclk = ~wclk;

    // Scoreboard state.
    logic [AW+DWIDTH-1:0] exp_q[$];  // expected BRAM writes {addr, data}
    logic [SW-1:0]        st_q[$];   // expected status {full, afull, wr_cnt, wptr_gray}
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;

    // Reference model state.
    int  writes;
    int  reads;
    int  rd_hist[$];
    bit  m_full;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] to_gray(input int n);
        logic [PW-1:0] b;
        b = PW'(n % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        writes = 0;
        reads  = 0;
        m_full = 1'b0;
        rd_hist.delete();
        rd_hist.push_back(0);
        rd_hist.push_back(0);
        exp_q.delete();
        st_q.delete();
        st_q.push_back('0);
    endtask

    // One cycle of stimulus. It is called just after a posedge and drives the
    // inputs for the next edge, then records what that edge must produce.
    task automatic step(input bit do_push, input bit do_read, input logic [DWIDTH-1:0] d);
        bit acc;
        int cnt;
        if (do_read && reads < writes) reads++;
        acc       = do_push && !m_full;
        push      = do_push;
        push_data = d;
        rptr_gray = to_gray(reads);
        if (acc) begin
            exp_q.push_back({AW'(writes % DEPTH), d});
            writes++;
        end
        rd_hist.push_back(reads);
        cnt = writes - rd_hist[0];
        void'(rd_hist.pop_front());
        m_full = (cnt == DEPTH);
        st_q.push_back({m_full, (cnt >= AFULL_TH), PW'(cnt), to_gray(writes)});
        @(posedge wclk);
        #1;
    endtask

    task automatic run_rand(input int n, input int push_pct, input int read_pct);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(99) < push_pct, $urandom_range(99) < read_pct, $urandom);
        end
    endtask

    // Monitor: checks status every cycle and each BRAM write when mem_wen is high.
    initial begin
        logic [SW-1:0]        s;
        logic [AW+DWIDTH-1:0] w;
        forever begin
            @(negedge wclk);
            if (mon_en) begin
                if (st_q.size() == 0) begin
                    chk("status_queue_empty", 32'd1, 32'd0);
                end else begin
                    s = st_q.pop_front();
                    chk("full",      32'(full),      32'(s[SW-1]));
                    chk("afull",     32'(afull),     32'(s[SW-2]));
                    chk("wr_cnt",    32'(wr_cnt),    32'(s[2*PW-1:PW]));
                    chk("wptr_gray", 32'(wptr_gray), 32'(s[PW-1:0]));
                end
                if (mem_wen) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 32'd1, 32'd0);
                    end else begin
                        w = exp_q.pop_front();
                        chk("mem_waddr", 32'(mem_waddr), 32'(w[AW+DWIDTH-1:DWIDTH]));
                        chk("mem_wdata", mem_wdata, w[DWIDTH-1:0]);
                    end
                end
            end
        end
    end

    // Stimulus and final report.
    initial begin
        arst      = 1'b1;
        push      = 1'b0;
        push_data = '0;
        rptr_gray = '0;
`ifdef FIFO_WR_OVF_CNT_EN
        ovf_clr   = 1'b0;
`endif
        #12;
        chk("reset_full",   32'(full),      32'd0);
        chk("reset_wr_cnt", 32'(wr_cnt),    32'd0);
        chk("reset_wptr",   32'(wptr_gray), 32'd0);
        @(posedge wclk);
        #1;
        arst = 1'b0;
        model_reset();
        mon_en = 1'b1;

        // Fill 16 words back-to-back, then push while full.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DWIDTH'(i));
        chk("fill_wptr_gray", 32'(wptr_gray), 32'h18);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hDEAD);
`ifdef FIFO_WR_OVF_CNT_EN
        chk("ovf_cnt_3", 32'(ovf_cnt), 32'd3);
        ovf_clr = 1'b1;
        step(1'b0, 1'b0, '0);
        ovf_clr = 1'b0;
        chk("ovf_cnt_clr", 32'(ovf_cnt), 32'd0);
`endif

        // One read from full, let it propagate, then push into address 0.
        step(1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, $urandom);

        // Drain and then alternate push/read across pointer wrap.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, '0);
        for (int i = 0; i < 80; i++) step(i % 2 == 0, i % 2 == 1, $urandom);

        // Mixed random traffic, light and then heavy.
        run_rand(300, 60, 50);
        run_rand(300, 90, 30);
        run_rand(40, 70, 70);

        // Asynchronous reset in mid-cycle with a push pending and the FIFO not full.
        while (m_full || writes == reads) step(1'b0, 1'b1, '0);
        mon_en = 1'b0;
        push   = 1'b1;
        #2;
        arst = 1'b1;
        #1;
        chk("midrst_full",    32'(full),      32'd0);
        chk("midrst_afull",   32'(afull),     32'd0);
        chk("midrst_wr_cnt",  32'(wr_cnt),    32'd0);
        chk("midrst_wptr",    32'(wptr_gray), 32'd0);
        chk("midrst_mem_wen", 32'(mem_wen),   32'd0);
        push      = 1'b0;
        rptr_gray = '0;
        @(posedge wclk);
        @(posedge wclk);
        #1;
        arst = 1'b0;
        model_reset();
        mon_en = 1'b1;

        // Reach 15 words, then push on the same cycle the read pointer advances.
        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0, $urandom);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b1, $urandom);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
        chk("simul_wr_cnt", 32'(wr_cnt), 32'd15);

        run_rand(200, 75, 50);

        push = 1'b0;
        @(negedge wclk);
        #1;
        mon_en = 1'b0;
        chk("status_left", 32'(st_q.size()), 32'd0);
        chk("writes_left", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
